wavefront_scheduler: RTL and testbench

- Layer-level sequencer for the input buffer bank and systolic array.
- Runs the IB handshake per input channel: start, wait ready, staggered per-column pops (wavefront), row-done pulse, then done.
- Loops over input channels, then reports layer completion to the top-level controller.
- The IB has no notion of channels or output rows; this block owns both.

---
 rtl/wavefront_scheduler_pkg.sv | 39 +++
 rtl/wavefront_scheduler_wave_pop_gen.sv | 29 ++
 rtl/wavefront_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_wavefront_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wavefront_scheduler_pkg.sv
// Shared types and constants for the layer-level wavefront scheduler.
package wavefront_scheduler_pkg;

    localparam int K_CHANNELS      = 8;
    localparam int WF_MAX_IN_CH    = 8;
    localparam int WF_BANK_WIDTH   = 32;
    // Refill latency beyond the W-cycle IB reload: one SRAM read cycle.
    localparam int WF_SETTLE_EXTRA = 1;

    typedef enum logic [2:0] {
        IDLE,
        START_IB,
        WAIT_READY,
        WAVE,
        ROW_END,
        CH_END,
        DONE
    } wf_state_t;

    // Layer config legality; all compares are 32-bit unsigned.
    function automatic logic wf_cfg_legal(
        input logic [31:0] w,
        input logic [31:0] h,
        input logic [3:0]  k,
        input logic [3:0]  c,
        input int unsigned bank_w,
        input int unsigned max_ch
    );
        logic [31:0] k32;
        logic [31:0] c32;
        k32 = 32'(k);
        c32 = 32'(c);
        return (k32 >= 32'd1) && (k32 <= h) &&
               (w >= 32'd1) && (w <= bank_w) &&
               (c32 >= 32'd1) && (c32 <= max_ch) &&
               (k32 <= w);
    endfunction

endpackage

// File: rtl/wavefront_scheduler_wave_pop_gen.sv
// Combinational wavefront pop pattern: column i pops for K cycles starting at t=i.
module wave_pop_gen #(
    parameter int BANK_WIDTH = 32,
    parameter int TW         = 6
) (
    input  logic [TW-1:0]         i_t,
    input  logic [3:0]            i_k,
    input  logic [31:0]           i_w,
    input  logic                  i_active,
    output logic [BANK_WIDTH-1:0] o_pop
);

    logic [31:0] w_t32;
    logic [31:0] w_k32;

    // Per-column window test i <= t <= i+K-1, masked to the first W columns.
    always_comb begin
        w_t32 = 32'(i_t);
        w_k32 = 32'(i_k);
        o_pop = '0;
        for (int unsigned i = 0; i < BANK_WIDTH; i++) begin
            if (i_active && (i < i_w) && (w_t32 >= i) &&
                (w_t32 <= i + w_k32 - 32'd1)) begin
                o_pop[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wavefront_scheduler.sv
// Layer sequencer: drives the IB handshake per input channel and output row,
// generating the staggered per-column pop wavefront.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | waiting for layer_start_i; config checked here
//  START_IB   | ib_start_o pulse for the current channel
//  WAIT_READY | wait for IB window valid (and settle count on rows > 0)
//  WAVE       | t = 0..W+K-2, pop wavefront active
//  ROW_END    | pre_wave_done_o pulse; next row or channel end
//  CH_END     | ib_sa_done_o pulse; next channel or layer done
//  DONE       | layer_done_o pulse, busy dropped
//
// All outputs are registered from the next-state values, so each pulse lines
// up with the cycle in which the state register holds the matching state.
module wavefront_scheduler
    import wavefront_scheduler_pkg::*;
#(
    parameter int BANK_WIDTH = WF_BANK_WIDTH,
    parameter int MAX_IN_CH  = WF_MAX_IN_CH
) (
    input  logic                         clk_i,
    input  logic                         rst_async_n_i,
    input  logic                         layer_start_i,
    input  logic                         abort_i,
    input  logic [31:0]                  cfg_img_w_i,
    input  logic [31:0]                  cfg_img_h_i,
    input  logic [3:0]                   cfg_kernel_r_i,
    input  logic [3:0]                   cfg_in_ch_i,
    input  logic                         ib_ready_i,
    output logic                         ib_start_o,
    output logic                         ib_sa_done_o,
    output logic [$clog2(MAX_IN_CH)-1:0] input_ch_sel_o,
    output logic [BANK_WIDTH-1:0]        pop_o,
    output logic                         pre_wave_done_o,
    output logic                         busy_o,
    output logic                         layer_done_o,
    output logic                         cfg_err_o
);

    localparam int CW = $clog2(MAX_IN_CH);
    localparam int TW = $clog2(BANK_WIDTH + 16);

    wf_state_t r_state;
    wf_state_t w_state_nxt;

    logic [TW-1:0]         r_t;
    logic [31:0]           r_row;
    logic [CW-1:0]         r_ch;
    logic [31:0]           r_settle;
    logic                  r_err;
    logic [31:0]           r_w;
    logic [3:0]            r_k;
    logic [3:0]            r_c;
    logic [31:0]           r_row_last;
    logic [31:0]           r_wave_last;
    logic [BANK_WIDTH-1:0] r_pop;
    logic                  r_ib_start;
    logic                  r_sa_done;
    logic                  r_pre_wave;
    logic                  r_busy;
    logic                  r_layer_done;

    logic [TW-1:0]         w_t_nxt;
    logic [31:0]           w_row_nxt;
    logic [CW-1:0]         w_ch_nxt;
    logic [31:0]           w_settle_nxt;
    logic                  w_err_nxt;
    logic                  w_latch;
    logic                  w_abort;
    logic                  w_legal;
    logic [BANK_WIDTH-1:0] w_pop;

    assign w_abort = abort_i && (r_state != IDLE);
    assign w_legal = wf_cfg_legal(cfg_img_w_i, cfg_img_h_i, cfg_kernel_r_i,
                                  cfg_in_ch_i, BANK_WIDTH, MAX_IN_CH);

    // State register.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) r_state <= IDLE;
        else                r_state <= w_state_nxt;
    end

    // Next-state and next counter values; abort overrides everything outside IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_t_nxt      = r_t;
        w_row_nxt    = r_row;
        w_ch_nxt     = r_ch;
        w_settle_nxt = r_settle;
        w_err_nxt    = r_err;
        w_latch      = 1'b0;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (layer_start_i && !abort_i) begin
                        if (w_legal) begin
                            w_latch      = 1'b1;
                            w_state_nxt  = START_IB;
                            w_ch_nxt     = '0;
                            w_row_nxt    = '0;
                            w_settle_nxt = '0;
                            w_err_nxt    = 1'b0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                START_IB: w_state_nxt = WAIT_READY;
                WAIT_READY: begin
                    if (r_settle != 32'd0) begin
                        w_settle_nxt = r_settle - 32'd1;
                    end else if (ib_ready_i) begin
                        w_state_nxt = WAVE;
                        w_t_nxt     = '0;
                    end
                end
                WAVE: begin
                    // ib_ready_i is deliberately ignored here: a wave never stalls.
                    if (32'(r_t) == r_wave_last) w_state_nxt = ROW_END;
                    else                         w_t_nxt     = r_t + TW'(1);
                end
                ROW_END: begin
                    if (r_row == r_row_last) begin
                        w_state_nxt = CH_END;
                    end else begin
                        w_row_nxt    = r_row + 32'd1;
                        w_settle_nxt = r_w + 32'(WF_SETTLE_EXTRA);
                        w_state_nxt  = WAIT_READY;
                    end
                end
                CH_END: begin
                    if (32'(r_ch) == 32'(r_c) - 32'd1) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_ch_nxt    = r_ch + CW'(1);
                        w_row_nxt   = '0;
                        w_state_nxt = START_IB;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    wave_pop_gen #(
        .BANK_WIDTH (BANK_WIDTH),
        .TW         (TW)
    ) u_pop_gen (
        .i_t      (w_t_nxt),
        .i_k      (r_k),
        .i_w      (r_w),
        .i_active (w_state_nxt == WAVE),
        .o_pop    (w_pop)
    );

    // Counters, latched config and registered outputs.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            r_t          <= '0;
            r_row        <= '0;
            r_ch         <= '0;
            r_settle     <= '0;
            r_err        <= 1'b0;
            r_w          <= '0;
            r_k          <= '0;
            r_c          <= '0;
            r_row_last   <= '0;
            r_wave_last  <= '0;
            r_pop        <= '0;
            r_ib_start   <= 1'b0;
            r_sa_done    <= 1'b0;
            r_pre_wave   <= 1'b0;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b0;
        end else begin
            r_t      <= w_t_nxt;
            r_row    <= w_row_nxt;
            r_ch     <= w_ch_nxt;
            r_settle <= w_settle_nxt;
            r_err    <= w_err_nxt;
            if (w_latch) begin
                // H-K and W+K-2 only formed once the config is known legal.
                r_w         <= cfg_img_w_i;
                r_k         <= cfg_kernel_r_i;
                r_c         <= cfg_in_ch_i;
                r_row_last  <= cfg_img_h_i - 32'(cfg_kernel_r_i);
                r_wave_last <= cfg_img_w_i + 32'(cfg_kernel_r_i) - 32'd2;
            end
            r_pop        <= w_pop;
            r_ib_start   <= (w_state_nxt == START_IB) && !w_abort;
            r_sa_done    <= (w_state_nxt == CH_END) || w_abort;
            r_pre_wave   <= (w_state_nxt == ROW_END);
            r_busy       <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
            r_layer_done <= (w_state_nxt == DONE);
        end
    end

    assign ib_start_o      = r_ib_start;
    assign ib_sa_done_o    = r_sa_done;
    assign input_ch_sel_o  = r_ch;
    assign pop_o           = r_pop;
    assign pre_wave_done_o = r_pre_wave;
    assign busy_o          = r_busy;
    assign layer_done_o    = r_layer_done;
    assign cfg_err_o       = r_err;

endmodule

// File: tb/tb_wavefront_scheduler.sv
// Directed bench for wavefront_scheduler: pulse counts, pop pattern, edge configs,
// config error, abort, mid-layer start and ready stall.
module tb_wavefront_scheduler;

    localparam int BW = 32;
    localparam int MC = 8;

    logic            clk_i = 1'b0;
    logic            rst_async_n_i = 1'b0;
    logic            layer_start_i = 1'b0;
    logic            abort_i = 1'b0;
    logic [31:0]     cfg_img_w_i = '0;
    logic [31:0]     cfg_img_h_i = '0;
    logic [3:0]      cfg_kernel_r_i = '0;
    logic [3:0]      cfg_in_ch_i = '0;
    logic            ib_ready_i = 1'b1;
    logic            ib_start_o;
    logic            ib_sa_done_o;
    logic [2:0]      input_ch_sel_o;
    logic [BW-1:0]   pop_o;
    logic            pre_wave_done_o;
    logic            busy_o;
    logic            layer_done_o;
    logic            cfg_err_o;

    wavefront_scheduler #(.BANK_WIDTH(BW), .MAX_IN_CH(MC)) dut (
        .clk_i           (clk_i),
        .rst_async_n_i   (rst_async_n_i),
        .layer_start_i   (layer_start_i),
        .abort_i         (abort_i),
        .cfg_img_w_i     (cfg_img_w_i),
        .cfg_img_h_i     (cfg_img_h_i),
        .cfg_kernel_r_i  (cfg_kernel_r_i),
        .cfg_in_ch_i     (cfg_in_ch_i),
        .ib_ready_i      (ib_ready_i),
        .ib_start_o      (ib_start_o),
        .ib_sa_done_o    (ib_sa_done_o),
        .input_ch_sel_o  (input_ch_sel_o),
        .pop_o           (pop_o),
        .pre_wave_done_o (pre_wave_done_o),
        .busy_o          (busy_o),
        .layer_done_o    (layer_done_o),
        .cfg_err_o       (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc, cnt_start, cnt_row, cnt_sa, cnt_done, cnt_pop_cyc;
    int cnt_col0, cnt_col3, cnt_hi, first_col0, first_col3, pw_first, gap;
    int ch_log[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        @(posedge clk_i);
        #1;
        cnt_start = 0; cnt_row = 0; cnt_sa = 0; cnt_done = 0; cnt_pop_cyc = 0;
        cnt_col0 = 0; cnt_col3 = 0; cnt_hi = 0;
        first_col0 = -1; first_col3 = -1; pw_first = -1; gap = -1;
        for (int i = 0; i < 8; i++) ch_log[i] = -1;
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (ib_start_o) begin
                if (cnt_start < 8) ch_log[cnt_start] = int'(input_ch_sel_o);
                cnt_start++;
            end
            if (pre_wave_done_o) begin
                cnt_row++;
                if (pw_first < 0) pw_first = cyc;
            end
            if (ib_sa_done_o) cnt_sa++;
            if (layer_done_o) cnt_done++;
            if (pop_o != '0) begin
                cnt_pop_cyc++;
                if (pw_first >= 0 && gap < 0) gap = cyc - pw_first;
            end
            if (pop_o[0]) begin
                cnt_col0++;
                if (first_col0 < 0) first_col0 = cyc;
            end
            if (pop_o[3]) begin
                cnt_col3++;
                if (first_col3 < 0) first_col3 = cyc;
            end
            if (pop_o[BW-1:4] != '0) cnt_hi++;
        end
    end

    task automatic start_layer(input int w, input int h, input int k, input int c);
        cfg_img_w_i    = 32'(w);
        cfg_img_h_i    = 32'(h);
        cfg_kernel_r_i = 4'(k);
        cfg_in_ch_i    = 4'(c);
        @(negedge clk_i);
        layer_start_i = 1'b1;
        @(negedge clk_i);
        layer_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int mid_pulse);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk_i);
            layer_start_i = (n == mid_pulse);
            if (layer_done_o) seen = 1'b1;
        end
        layer_start_i = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        bit seen;
        clear_counts();
        repeat (2) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_pop", pop_o, 0);
        chk("rst_err", 32'(cfg_err_o), 0);
        chk("rst_ibstart", 32'(ib_start_o), 0);
        rst_async_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_ch", 32'(input_ch_sel_o), 0);
        chk("rst_done", 32'(layer_done_o), 0);

        // W=4 H=6 K=3 C=1: 4 waves of 6 cycles.
        clear_counts();
        start_layer(4, 6, 3, 1);
        wait_done(2000, -1);
        chk("t1_start", cnt_start, 1);
        chk("t1_rows", cnt_row, 4);
        chk("t1_sa", cnt_sa, 1);
        chk("t1_done", cnt_done, 1);
        chk("t1_popcyc", cnt_pop_cyc, 24);
        chk("t1_col0", cnt_col0, 12);
        chk("t1_col3", cnt_col3, 12);
        chk("t1_hi", cnt_hi, 0);
        chk("t1_stagger", 32'(first_col3 - first_col0), 3);
        chk("t1_gap_ok", 32'(gap >= 5), 1);
        chk("t1_busy_end", 32'(busy_o), 0);

        // W=4 H=5 K=3 C=3 with a stray start mid-layer.
        clear_counts();
        start_layer(4, 5, 3, 3);
        wait_done(3000, 30);
        chk("t2_start", cnt_start, 3);
        chk("t2_rows", cnt_row, 9);
        chk("t2_sa", cnt_sa, 3);
        chk("t2_done", cnt_done, 1);
        chk("t2_ch0", ch_log[0], 0);
        chk("t2_ch1", ch_log[1], 1);
        chk("t2_ch2", ch_log[2], 2);

        // K=1 W=1 H=1: single one-cycle wave.
        clear_counts();
        start_layer(1, 1, 1, 1);
        wait_done(500, -1);
        chk("t3_rows", cnt_row, 1);
        chk("t3_popcyc", cnt_pop_cyc, 1);
        chk("t3_col0", cnt_col0, 1);

        // H==K, two channels: one wave per channel.
        clear_counts();
        start_layer(3, 3, 3, 2);
        wait_done(1000, -1);
        chk("t4_rows", cnt_row, 2);
        chk("t4_start", cnt_start, 2);
        chk("t4_popcyc", cnt_pop_cyc, 10);

        // W = BANK_WIDTH+1 is rejected.
        clear_counts();
        start_layer(BW + 1, 4, 2, 1);
        repeat (4) @(negedge clk_i);
        chk("t5_err", 32'(cfg_err_o), 1);
        chk("t5_busy", 32'(busy_o), 0);
        chk("t5_start", cnt_start, 0);

        // Legal layer clears the error; ready held low 20 cycles stalls the wave.
        clear_counts();
        ib_ready_i = 1'b0;
        start_layer(2, 2, 1, 1);
        repeat (20) @(negedge clk_i);
        chk("t6_err_clr", 32'(cfg_err_o), 0);
        chk("t6_stall_pop", cnt_pop_cyc, 0);
        chk("t6_stall_busy", 32'(busy_o), 1);
        ib_ready_i = 1'b1;
        wait_done(500, -1);
        chk("t6_rows", cnt_row, 2);
        chk("t6_popcyc", cnt_pop_cyc, 4);

        // Abort at wave t=2.
        clear_counts();
        start_layer(4, 6, 3, 1);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk_i);
            if (pop_o != '0) seen = 1'b1;
        end
        chk("t7_wave_seen", 32'(seen), 1);
        repeat (2) @(negedge clk_i);
        chk("t7_pop_t2", 32'(pop_o[3:0]), 32'h7);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("t7_pop_off", pop_o, 0);
        chk("t7_sa", 32'(ib_sa_done_o), 1);
        chk("t7_busy", 32'(busy_o), 0);
        repeat (20) @(negedge clk_i);
        chk("t7_no_done", cnt_done, 0);
        chk("t7_sa_cnt", cnt_sa, 1);

        // Abort together with start in IDLE: start ignored.
        clear_counts();
        @(negedge clk_i);
        abort_i = 1'b1;
        layer_start_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        layer_start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("t8_start", cnt_start, 0);
        chk("t8_busy", 32'(busy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
